// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD 24-hour time-of-day counter with per-second prescaler and per-digit adjust
module time_counter #(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Enable_Count,
  input  logic        i_Seconds_1st_Digit_Inc,
  input  logic        i_Seconds_1st_Digit_Dec,
  input  logic        i_Seconds_2nd_Digit_Inc,
  input  logic        i_Seconds_2nd_Digit_Dec,
  input  logic        i_Minutes_1st_Digit_Inc,
  input  logic        i_Minutes_1st_Digit_Dec,
  input  logic        i_Minutes_2nd_Digit_Inc,
  input  logic        i_Minutes_2nd_Digit_Dec,
  input  logic        i_Hours_1st_Digit_Inc,
  input  logic        i_Hours_1st_Digit_Dec,
  input  logic        i_Hours_2nd_Digit_Inc,
  input  logic        i_Hours_2nd_Digit_Dec,
  output logic [31:0] o_Time,
  output logic        o_Second_Tick,
  output logic        o_Midnight
);

  localparam int PW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] presc;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic [3:0] n_s1, n_s2, n_m1, n_m2, n_h1, n_h2;
  logic [3:0] a_s1, a_s2, a_m1, a_m2, a_h1, a_h2;
  logic [3:0] h1_max;
  logic       cmd_hit, due, at_midnight;

  assign due         = i_Enable_Count && (presc == LAST);
  assign h1_max      = (h2 == 4'd2) ? 4'd3 : 4'd9;
  assign at_midnight = (h2 == 4'd2) && (h1 == 4'd3) && (m2 == 4'd5) && (m1 == 4'd9)
                       && (s2 == 4'd5) && (s1 == 4'd9);

  // Manual adjust: first digit with any command asserted wins; inc+dec together is a no-op.
  always_comb begin
    n_s1 = s1; n_s2 = s2; n_m1 = m1; n_m2 = m2; n_h1 = h1; n_h2 = h2;
    cmd_hit = 1'b1;
    if (i_Seconds_1st_Digit_Inc || i_Seconds_1st_Digit_Dec) begin
      if (i_Seconds_1st_Digit_Inc && !i_Seconds_1st_Digit_Dec)
        n_s1 = (s1 == 4'd9) ? 4'd0 : s1 + 4'd1;
      else if (i_Seconds_1st_Digit_Dec && !i_Seconds_1st_Digit_Inc)
        n_s1 = (s1 == 4'd0) ? 4'd9 : s1 - 4'd1;
    end else if (i_Seconds_2nd_Digit_Inc || i_Seconds_2nd_Digit_Dec) begin
      if (i_Seconds_2nd_Digit_Inc && !i_Seconds_2nd_Digit_Dec)
        n_s2 = (s2 == 4'd5) ? 4'd0 : s2 + 4'd1;
      else if (i_Seconds_2nd_Digit_Dec && !i_Seconds_2nd_Digit_Inc)
        n_s2 = (s2 == 4'd0) ? 4'd5 : s2 - 4'd1;
    end else if (i_Minutes_1st_Digit_Inc || i_Minutes_1st_Digit_Dec) begin
      if (i_Minutes_1st_Digit_Inc && !i_Minutes_1st_Digit_Dec)
        n_m1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
      else if (i_Minutes_1st_Digit_Dec && !i_Minutes_1st_Digit_Inc)
        n_m1 = (m1 == 4'd0) ? 4'd9 : m1 - 4'd1;
    end else if (i_Minutes_2nd_Digit_Inc || i_Minutes_2nd_Digit_Dec) begin
      if (i_Minutes_2nd_Digit_Inc && !i_Minutes_2nd_Digit_Dec)
        n_m2 = (m2 == 4'd5) ? 4'd0 : m2 + 4'd1;
      else if (i_Minutes_2nd_Digit_Dec && !i_Minutes_2nd_Digit_Inc)
        n_m2 = (m2 == 4'd0) ? 4'd5 : m2 - 4'd1;
    end else if (i_Hours_1st_Digit_Inc || i_Hours_1st_Digit_Dec) begin
      if (i_Hours_1st_Digit_Inc && !i_Hours_1st_Digit_Dec)
        n_h1 = (h1 >= h1_max) ? 4'd0 : h1 + 4'd1;
      else if (i_Hours_1st_Digit_Dec && !i_Hours_1st_Digit_Inc)
        n_h1 = (h1 == 4'd0) ? h1_max : h1 - 4'd1;
    end else if (i_Hours_2nd_Digit_Inc || i_Hours_2nd_Digit_Dec) begin
      if (i_Hours_2nd_Digit_Inc && !i_Hours_2nd_Digit_Dec)
        n_h2 = (h2 >= 4'd2) ? 4'd0 : h2 + 4'd1;
      else if (i_Hours_2nd_Digit_Dec && !i_Hours_2nd_Digit_Inc)
        n_h2 = (h2 == 4'd0) ? 4'd2 : h2 - 4'd1;
      // Moving into the 20s must not leave an illegal 24..29.
      if (n_h2 == 4'd2 && h1 > 4'd3)
        n_h1 = 4'd3;
    end else begin
      cmd_hit = 1'b0;
    end
  end

  // One-second advance with full carry chain.
  always_comb begin
    a_s1 = s1; a_s2 = s2; a_m1 = m1; a_m2 = m2; a_h1 = h1; a_h2 = h2;
    if (s1 != 4'd9) begin
      a_s1 = s1 + 4'd1;
    end else begin
      a_s1 = 4'd0;
      if (s2 != 4'd5) begin
        a_s2 = s2 + 4'd1;
      end else begin
        a_s2 = 4'd0;
        if (m1 != 4'd9) begin
          a_m1 = m1 + 4'd1;
        end else begin
          a_m1 = 4'd0;
          if (m2 != 4'd5) begin
            a_m2 = m2 + 4'd1;
          end else begin
            a_m2 = 4'd0;
            if (h2 == 4'd2 && h1 == 4'd3) begin
              a_h2 = 4'd0;
              a_h1 = 4'd0;
            end else if (h1 == 4'd9) begin
              a_h1 = 4'd0;
              a_h2 = h2 + 4'd1;
            end else begin
              a_h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc         <= '0;
      s1 <= 4'd0; s2 <= 4'd0; m1 <= 4'd0; m2 <= 4'd0; h1 <= 4'd0; h2 <= 4'd0;
      o_Second_Tick <= 1'b0;
      o_Midnight    <= 1'b0;
    end else begin
      o_Second_Tick <= 1'b0;
      o_Midnight    <= 1'b0;
      if (!i_Enable_Count || presc == LAST)
        presc <= '0;
      else
        presc <= presc + 1'b1;
      if (cmd_hit) begin
        s1 <= n_s1; s2 <= n_s2; m1 <= n_m1; m2 <= n_m2; h1 <= n_h1; h2 <= n_h2;
      end else if (due) begin
        s1 <= a_s1; s2 <= a_s2; m1 <= a_m1; m2 <= a_m2; h1 <= a_h1; h2 <= a_h2;
        o_Second_Tick <= 1'b1;
        o_Midnight    <= at_midnight;
      end
    end
  end

  assign o_Time = {8'h00, h2, h1, m2, m1, s2, s1};

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed self-checking bench for time_counter at CLK_FREQ_HZ=4
module tb_time_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] cmd;
  logic [31:0] t;
  logic        tick, mid;
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [11:0] S1I = 12'h001, S1D = 12'h002, S2I = 12'h004, S2D = 12'h008;
  localparam logic [11:0] M1I = 12'h010, M1D = 12'h020, M2I = 12'h040, M2D = 12'h080;
  localparam logic [11:0] H1I = 12'h100, H1D = 12'h200, H2I = 12'h400, H2D = 12'h800;

  always #5 clk = ~clk;

  time_counter #(.CLK_FREQ_HZ(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable_Count(en),
    .i_Seconds_1st_Digit_Inc(cmd[0]),  .i_Seconds_1st_Digit_Dec(cmd[1]),
    .i_Seconds_2nd_Digit_Inc(cmd[2]),  .i_Seconds_2nd_Digit_Dec(cmd[3]),
    .i_Minutes_1st_Digit_Inc(cmd[4]),  .i_Minutes_1st_Digit_Dec(cmd[5]),
    .i_Minutes_2nd_Digit_Inc(cmd[6]),  .i_Minutes_2nd_Digit_Dec(cmd[7]),
    .i_Hours_1st_Digit_Inc(cmd[8]),    .i_Hours_1st_Digit_Dec(cmd[9]),
    .i_Hours_2nd_Digit_Inc(cmd[10]),   .i_Hours_2nd_Digit_Dec(cmd[11]),
    .o_Time(t), .o_Second_Tick(tick), .o_Midnight(mid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [11:0] c);
    cmd = c;
    step(1);
    cmd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Advance n cycles expecting no tick, then one cycle with a tick and the given time.
  task automatic second(input string tag, input int quiet, input logic [31:0] exp_t);
    for (int i = 0; i < quiet; i++) begin
      step(1);
      check({tag, "_quiet_tick"}, {31'd0, tick}, 32'd0);
    end
    step(1);
    check({tag, "_time"}, t, exp_t);
    check({tag, "_tick"}, {31'd0, tick}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cmd = '0;
    step(2);
    check("reset_time", t, 32'h0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    check("reset_mid",  {31'd0, mid},  32'd0);
    rst = 1'b0;

    // Free-running count: advances at cycles 4, 8, 12
    en = 1'b1;
    second("sec1", 3, 32'h00000001);
    second("sec2", 3, 32'h00000002);
    second("sec3", 3, 32'h00000003);
    check("sec3_mid", {31'd0, mid}, 32'd0);
    en = 1'b0;

    // Load 23:59:59 and roll over midnight
    do_reset();
    pulse(S1D); pulse(S2D); pulse(M1D); pulse(M2D); pulse(H2D); pulse(H1D);
    check("load_235959", t, 32'h00235959);
    check("adjust_no_tick", {31'd0, tick}, 32'd0);
    en = 1'b1;
    second("midnight", 3, 32'h00000000);
    check("midnight_pulse", {31'd0, mid}, 32'd1);
    step(1);
    check("midnight_one_cycle", {31'd0, mid}, 32'd0);
    check("tick_one_cycle", {31'd0, tick}, 32'd0);
    en = 1'b0;

    // Seconds digit wrap without carry
    do_reset();
    pulse(S2D); pulse(S1D);
    check("load_59", t, 32'h00000059);
    pulse(S1I);
    check("s1_wrap_up", t, 32'h00000050);
    pulse(S2I);
    check("s2_wrap_up", t, 32'h00000000);
    pulse(S2D);
    check("s2_wrap_down", t, 32'h00000050);

    // Hours range and clamp
    do_reset();
    pulse(H2I); pulse(H1D);
    check("load_19", t, 32'h00190000);
    pulse(H2I);
    check("h2_clamp", t, 32'h00230000);
    pulse(H1I);
    check("h1_wrap_up_20s", t, 32'h00200000);
    pulse(H1D);
    check("h1_wrap_down_20s", t, 32'h00230000);

    // Priority and conflicting commands
    pulse(M1I | M1D | H2I);
    check("conflict_nochange", t, 32'h00230000);
    pulse(S1I | M1I);
    check("priority_seconds", t, 32'h00230001);
    pulse(H2I);
    check("h2_wrap_2_to_0", t, 32'h00030001);

    // Held command steps once per cycle
    cmd = M2I;
    step(3);
    cmd = '0;
    check("held_m2", t, 32'h00033001);

    // Command collides with due advance: command wins, no tick
    do_reset();
    en = 1'b1;
    step(3);
    pulse(S2I);
    check("collide_time", t, 32'h00000010);
    check("collide_no_tick", {31'd0, tick}, 32'd0);
    second("after_collide", 3, 32'h00000011);
    en = 1'b0;

    // Enable gap clears prescaler
    do_reset();
    en = 1'b1;
    step(3);
    en = 1'b0;
    step(5);
    check("gap_time", t, 32'h0);
    check("gap_tick", {31'd0, tick}, 32'd0);
    en = 1'b1;
    second("reenable", 3, 32'h00000001);

    // Reset at prescaler=3 discards the pending advance
    step(3);
    rst = 1'b1;
    step(1);
    check("rst_mid_time", t, 32'h0);
    check("rst_mid_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    second("after_rst", 3, 32'h00000001);
    en = 1'b0;
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
